// File: rtl/axil_strobe_bridge.sv
// AXI4-Lite slave fanning one register bus out to N_TARGETS strobe/ack targets.
// One transaction in flight, read/write round-robin, ack timeout and decode errors.
module axil_strobe_bridge #(
    parameter int N_TARGETS = 4,
    parameter int SEL_LSB   = 8,
    parameter int SEL_BITS  = 4,
    parameter int TGT_AW    = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                    axilClk,
    input  logic                    axilRst,
    input  logic [31:0]             axil_araddr,
    input  logic                    axil_arvalid,
    output logic                    axil_arready,
    output logic [31:0]             axil_rdata,
    output logic [1:0]              axil_rresp,
    output logic                    axil_rvalid,
    input  logic                    axil_rready,
    input  logic [31:0]             axil_awaddr,
    input  logic                    axil_awvalid,
    output logic                    axil_awready,
    input  logic [31:0]             axil_wdata,
    input  logic [3:0]              axil_wstrb,
    input  logic                    axil_wvalid,
    output logic                    axil_wready,
    output logic [1:0]              axil_bresp,
    output logic                    axil_bvalid,
    input  logic                    axil_bready,
    output logic [TGT_AW-1:0]       tgt_addr,
    output logic [31:0]             tgt_wdata,
    output logic [N_TARGETS-1:0]    tgt_wstr,
    output logic [N_TARGETS-1:0]    tgt_rstr,
    input  logic [N_TARGETS-1:0]    tgt_wack,
    input  logic [N_TARGETS-1:0]    tgt_rack,
    input  logic [32*N_TARGETS-1:0] tgt_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_STB, S_RESP} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    function automatic logic [SEL_BITS-1:0] addr_sel(input logic [31:0] a);
        return a[SEL_LSB+2 +: SEL_BITS];
    endfunction

    function automatic logic [TGT_AW-1:0] addr_word(input logic [31:0] a);
        return a[2 +: TGT_AW];
    endfunction

    logic [1:0]           rst_sync_q, rst_sync_d;
    logic                 rst_i;
    state_t               state_q, state_d;
    logic                 is_wr_q, is_wr_d;
    logic                 prefer_wr_q, prefer_wr_d;
    logic [SEL_BITS-1:0]  sel_q, sel_d;
    logic [TGT_AW-1:0]    addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [15:0]          timer_q, timer_d;
    logic                 arready_q, arready_d;
    logic                 awready_q, awready_d;
    logic                 rvalid_q, rvalid_d;
    logic                 bvalid_q, bvalid_d;
    logic [1:0]           rresp_q, rresp_d;
    logic [1:0]           bresp_q, bresp_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [N_TARGETS-1:0] wstr_q, wstr_d;
    logic [N_TARGETS-1:0] rstr_q, rstr_d;

    logic [N_TARGETS-1:0] sel_oh_s;
    logic [31:0]          sel_rdata_s;
    logic                 ack_hit_s;
    logic                 wr_cand_s, grant_rd_s, grant_wr_s;
    logic                 resp_fire_s;
    logic [1:0]           resp_code_s;
    logic [31:0]          resp_data_s;
    logic                 unused_addr_s;

    // Address bits outside the select and word fields are deliberately ignored.
    assign unused_addr_s = ^{axil_araddr, axil_awaddr};

    // Reset synchroniser: assertion is immediate, release waits two clocks.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b0};
    end

    // Reset synchroniser register.
    always_ff @(posedge axilClk or posedge axilRst) begin
        if (axilRst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_i = rst_sync_q[1];

    // Target decode: one-hot select, ack of the selected target and its read data.
    always_comb begin
        sel_oh_s    = '0;
        sel_rdata_s = 32'h0000_0000;
        for (int k = 0; k < N_TARGETS; k++) begin
            sel_oh_s[k] = (sel_q == SEL_BITS'(k));
            sel_rdata_s = sel_rdata_s | (tgt_rdata[32*k +: 32] & {32{sel_oh_s[k]}});
        end
        ack_hit_s = |((is_wr_q ? tgt_wack : tgt_rack) & sel_oh_s);
    end

    // Round-robin arbitration between a pending read and a complete write request.
    always_comb begin
        wr_cand_s  = axil_awvalid & axil_wvalid;
        grant_rd_s = axil_arvalid & ~(wr_cand_s & prefer_wr_q);
        grant_wr_s = wr_cand_s & ~grant_rd_s;
    end

    // Transaction FSM: next state, latched request and registered outputs.
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        prefer_wr_d = prefer_wr_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        timer_d     = timer_q;
        arready_d   = arready_q;
        awready_d   = awready_q;
        rvalid_d    = rvalid_q;
        bvalid_d    = bvalid_q;
        rresp_d     = rresp_q;
        bresp_d     = bresp_q;
        rdata_d     = rdata_q;
        wstr_d      = wstr_q;
        rstr_d      = rstr_q;
        resp_fire_s = 1'b0;
        resp_code_s = 2'b00;
        resp_data_s = 32'h0000_0000;

        case (state_q)
            S_IDLE: begin
                if (grant_rd_s) begin
                    state_d     = S_ACC;
                    is_wr_d     = 1'b0;
                    prefer_wr_d = 1'b1;
                    arready_d   = 1'b1;
                    sel_d       = addr_sel(axil_araddr);
                    addr_d      = addr_word(axil_araddr);
                end else if (grant_wr_s) begin
                    state_d     = S_ACC;
                    is_wr_d     = 1'b1;
                    prefer_wr_d = 1'b0;
                    awready_d   = 1'b1;
                    sel_d       = addr_sel(axil_awaddr);
                    addr_d      = addr_word(axil_awaddr);
                    wdata_d     = axil_wdata;
                    wstrb_d     = axil_wstrb;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACC: begin
                arready_d = 1'b0;
                awready_d = 1'b0;
                timer_d   = 16'd0;
                if (~|sel_oh_s) begin
                    resp_fire_s = 1'b1;
                    resp_code_s = 2'b11;
                end else if (is_wr_q && (wstrb_q != 4'hF)) begin
                    resp_fire_s = 1'b1;
                    resp_code_s = 2'b10;
                end else begin
                    state_d = S_STB;
                    wstr_d  = is_wr_q ? sel_oh_s : '0;
                    rstr_d  = is_wr_q ? '0 : sel_oh_s;
                end
            end
            S_STB: begin
                if (ack_hit_s) begin
                    resp_fire_s = 1'b1;
                    resp_code_s = 2'b00;
                    resp_data_s = sel_rdata_s;
                end else if (timer_q == TMO_LAST) begin
                    resp_fire_s = 1'b1;
                    resp_code_s = 2'b10;
                    resp_data_s = 32'hDEAD_DEAD;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_RESP: begin
                if (is_wr_q ? axil_bready : axil_rready) begin
                    rvalid_d = 1'b0;
                    bvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Completion from ACC or STB: drop strobes and present the response.
        if (resp_fire_s) begin
            state_d = S_RESP;
            wstr_d  = '0;
            rstr_d  = '0;
            timer_d = 16'd0;
            if (is_wr_q) begin
                bvalid_d = 1'b1;
                bresp_d  = resp_code_s;
            end else begin
                rvalid_d = 1'b1;
                rresp_d  = resp_code_s;
                rdata_d  = resp_data_s;
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State and output registers.
    always_ff @(posedge axilClk or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            is_wr_q     <= 1'b0;
            prefer_wr_q <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= 32'h0000_0000;
            wstrb_q     <= 4'h0;
            timer_q     <= 16'd0;
            arready_q   <= 1'b0;
            awready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            rresp_q     <= 2'b00;
            bresp_q     <= 2'b00;
            rdata_q     <= 32'h0000_0000;
            wstr_q      <= '0;
            rstr_q      <= '0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            prefer_wr_q <= prefer_wr_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            timer_q     <= timer_d;
            arready_q   <= arready_d;
            awready_q   <= awready_d;
            rvalid_q    <= rvalid_d;
            bvalid_q    <= bvalid_d;
            rresp_q     <= rresp_d;
            bresp_q     <= bresp_d;
            rdata_q     <= rdata_d;
            wstr_q      <= wstr_d;
            rstr_q      <= rstr_d;
        end
    end

    assign axil_arready = arready_q;
    assign axil_awready = awready_q;
    assign axil_wready  = awready_q;
    assign axil_rvalid  = rvalid_q;
    assign axil_rresp   = rresp_q;
    assign axil_rdata   = rdata_q;
    assign axil_bvalid  = bvalid_q;
    assign axil_bresp   = bresp_q;
    assign tgt_addr     = addr_q;
    assign tgt_wdata    = wdata_q;
    assign tgt_wstr     = wstr_q;
    assign tgt_rstr     = rstr_q;

endmodule

// File: tb/tb_axil_strobe_bridge.sv
// Directed self-checking bench for axil_strobe_bridge (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axil_strobe_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  araddr, awaddr, wdata;
    logic         arvalid, rready, awvalid, wvalid, bready;
    logic [3:0]   wstrb;
    logic         arready, rvalid, awready, wready, bvalid;
    logic [31:0]  rdata, tgt_wdata;
    logic [1:0]   rresp, bresp;
    logic [7:0]   tgt_addr;
    logic [3:0]   tgt_wstr, tgt_rstr, tgt_wack, tgt_rack;
    logic [127:0] tgt_rdata;
    logic [3:0]   auto_rack, auto_wack, man_rack, man_wack;
    int           checks = 0;
    int           failures = 0;
    int           cnt;

    always #5 clk = ~clk;

    assign tgt_rack  = (tgt_rstr & auto_rack) | man_rack;
    assign tgt_wack  = (tgt_wstr & auto_wack) | man_wack;
    assign tgt_rdata = {32'hCAFE_0003, 32'h1234_5678, 32'h0BAD_0001, 32'h5555_0000};

    axil_strobe_bridge dut (
        .axilClk(clk), .axilRst(rst),
        .axil_araddr(araddr), .axil_arvalid(arvalid), .axil_arready(arready),
        .axil_rdata(rdata), .axil_rresp(rresp), .axil_rvalid(rvalid), .axil_rready(rready),
        .axil_awaddr(awaddr), .axil_awvalid(awvalid), .axil_awready(awready),
        .axil_wdata(wdata), .axil_wstrb(wstrb), .axil_wvalid(wvalid), .axil_wready(wready),
        .axil_bresp(bresp), .axil_bvalid(bvalid), .axil_bready(bready),
        .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata), .tgt_wstr(tgt_wstr), .tgt_rstr(tgt_rstr),
        .tgt_wack(tgt_wack), .tgt_rack(tgt_rack), .tgt_rdata(tgt_rdata)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return arready;
            1:       return awready;
            2:       return rvalid;
            3:       return bvalid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_on(input int which, input int bound, input string tag);
        int n = 0;
        while (!sig_of(which) && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(sig_of(which)), 32'd1);
    endtask

    task automatic start_read(input logic [31:0] addr, input string tag);
        araddr  = addr;
        arvalid = 1'b1;
        wait_on(0, 4, tag);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic start_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input string tag);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        wait_on(1, 4, tag);
        check({tag, "_wready"}, 32'(wready), 32'd1);
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        araddr = 32'h0; awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
        arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        auto_rack = 4'h0; auto_wack = 4'h0; man_rack = 4'h0; man_wack = 4'h0;
        tick(); tick();
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_strobes", 32'({tgt_rstr, tgt_wstr}), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_tgt_addr", 32'(tgt_addr), 32'h0);
        rst = 1'b0;
        tick(); tick(); tick();

        // Read target 2 (word 0x282), ack 3 cycles after strobe, stray ack from target 0.
        start_read(32'h0000_0A08, "t1_arready");
        check("t1_rstr", 32'(tgt_rstr), 32'h4);
        check("t1_tgt_addr", 32'(tgt_addr), 32'h82);
        cnt = 0;
        while (tgt_rstr[2] && cnt < 20) begin
            cnt++;
            if (cnt == 2) man_rack = 4'b0001;
            if (cnt == 4) man_rack = 4'b0100;
            tick();
        end
        man_rack = 4'h0;
        check("t1_rstr_len", 32'(cnt), 32'd4);
        check("t1_rvalid", 32'(rvalid), 32'd1);
        check("t1_rdata", rdata, 32'h1234_5678);
        check("t1_rresp", 32'(rresp), 32'd0);
        rready = 1'b1; tick(); rready = 1'b0;
        check("t1_rvalid_clr", 32'(rvalid), 32'd0);

        // Write target 0, ack in the same cycle as the strobe.
        auto_wack = 4'hF;
        start_write(32'h0000_0010, 32'hA5A5_0001, 4'hF, "t2_awready");
        check("t2_wstr", 32'(tgt_wstr), 32'h1);
        check("t2_tgt_wdata", tgt_wdata, 32'hA5A5_0001);
        cnt = 0;
        while (tgt_wstr[0] && cnt < 20) begin cnt++; tick(); end
        check("t2_wstr_len", 32'(cnt), 32'd1);
        check("t2_bvalid", 32'(bvalid), 32'd1);
        check("t2_bresp", 32'(bresp), 32'd0);
        bready = 1'b1; tick(); bready = 1'b0;
        check("t2_bvalid_clr", 32'(bvalid), 32'd0);

        // Partial write strobes: no target strobe, SLVERR.
        start_write(32'h0000_0010, 32'h0000_0077, 4'h3, "t2b_awready");
        check("t2b_wstr", 32'(tgt_wstr), 32'h0);
        check("t2b_bvalid", 32'(bvalid), 32'd1);
        check("t2b_bresp", 32'(bresp), 32'd2);
        bready = 1'b1; tick(); bready = 1'b0;

        // Unmapped target 7: DECERR, zero data, no strobe.
        auto_rack = 4'hF;
        start_read(32'h0000_1C00, "t3_arready");
        check("t3_rstr", 32'(tgt_rstr), 32'h0);
        check("t3_rvalid", 32'(rvalid), 32'd1);
        check("t3_rresp", 32'(rresp), 32'd3);
        check("t3_rdata", rdata, 32'h0);
        rready = 1'b1; tick(); rready = 1'b0;

        // Write timeout on target 1, late ack ignored.
        auto_wack = 4'h0;
        start_write(32'h0000_0400, 32'h0000_BEEF, 4'hF, "t4_awready");
        cnt = 0;
        while (tgt_wstr[1] && cnt < 400) begin cnt++; tick(); end
        check("t4_wstr_len", 32'(cnt), 32'd255);
        check("t4_bvalid", 32'(bvalid), 32'd1);
        check("t4_bresp", 32'(bresp), 32'd2);
        man_wack = 4'b0010; tick();
        check("t4_late_bvalid", 32'(bvalid), 32'd1);
        check("t4_late_bresp", 32'(bresp), 32'd2);
        check("t4_late_wstr", 32'(tgt_wstr), 32'h0);
        man_wack = 4'h0;
        bready = 1'b1; tick(); bready = 1'b0;

        // Read timeout on target 3.
        auto_rack = 4'h0;
        start_read(32'h0000_0C00, "t4b_arready");
        cnt = 0;
        while (tgt_rstr[3] && cnt < 400) begin cnt++; tick(); end
        check("t4b_rstr_len", 32'(cnt), 32'd255);
        check("t4b_rresp", 32'(rresp), 32'd2);
        check("t4b_rdata", rdata, 32'hDEAD_DEAD);
        rready = 1'b1; tick(); rready = 1'b0;

        // Next write after the timeouts completes normally.
        auto_wack = 4'hF; auto_rack = 4'hF;
        start_write(32'h0000_0404, 32'h0000_0042, 4'hF, "t4c_awready");
        wait_on(3, 5, "t4c_bvalid");
        check("t4c_bresp", 32'(bresp), 32'd0);
        bready = 1'b1; tick(); bready = 1'b0;

        // Simultaneous read and write, twice: read, write, then read again.
        araddr = 32'h0000_0C00; arvalid = 1'b1;
        awaddr = 32'h0000_0000; wdata = 32'h1111_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        check("t5_first_ar", 32'(arready), 32'd1);
        check("t5_first_aw", 32'(awready), 32'd0);
        tick(); arvalid = 1'b0;
        rready = 1'b1;
        wait_on(2, 5, "t5_rvalid");
        check("t5_rdata", rdata, 32'hCAFE_0003);
        tick(); rready = 1'b0;
        wait_on(1, 5, "t5_second_aw");
        tick(); awvalid = 1'b0; wvalid = 1'b0;
        wait_on(3, 5, "t5_bvalid");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_bvalid_hold", 32'(bvalid), 32'd1);
            check("t5_bresp_hold", 32'(bresp), 32'd0);
        end
        bready = 1'b1; tick(); bready = 1'b0;
        check("t5_bvalid_clr", 32'(bvalid), 32'd0);
        araddr = 32'h0000_0800; arvalid = 1'b1;
        awaddr = 32'h0000_0400; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        check("t5_third_ar", 32'(arready), 32'd1);
        check("t5_third_aw", 32'(awready), 32'd0);
        tick(); arvalid = 1'b0;
        rready = 1'b1;
        wait_on(2, 5, "t5_rvalid2");
        check("t5_rdata2", rdata, 32'h1234_5678);
        tick(); rready = 1'b0;
        wait_on(1, 5, "t5_fourth_aw");
        tick(); awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        wait_on(3, 5, "t5_bvalid2");
        tick(); bready = 1'b0;

        // Asynchronous reset during a read strobe, then a clean read.
        auto_rack = 4'h0;
        start_read(32'h0000_0800, "t6_arready");
        check("t6_rstr", 32'(tgt_rstr), 32'h4);
        #2 rst = 1'b1;
        #1;
        check("t6_rstr_rst", 32'(tgt_rstr), 32'h0);
        check("t6_rvalid_rst", 32'(rvalid), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        auto_rack = 4'hF;
        start_read(32'h0000_0800, "t6_post_arready");
        wait_on(2, 5, "t6_post_rvalid");
        check("t6_post_rdata", rdata, 32'h1234_5678);
        check("t6_post_rresp", 32'(rresp), 32'd0);
        rready = 1'b1; tick(); rready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
